// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle ALU sequencer: state indices,
// operation codes, control-word bit positions and a one-hot helper.
`timescale 1ns/1ps
package alu_seq_ctrl_pkg;

  // Bit positions inside the one-hot state register (one bit per state).
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD   = 4'd1,
    ST_INIT   = 4'd2,
    ST_ALU    = 4'd3,
    ST_BOOTH  = 4'd4,
    ST_SHR    = 4'd5,
    ST_DSHL   = 4'd6,
    ST_DALU   = 4'd7,
    ST_DQ     = 4'd8,
    ST_DFIX   = 4'd9,
    ST_OUT_LO = 4'd10,
    ST_OUT_HI = 4'd11,
    ST_ERR    = 4'd12,
    ST_DONE   = 4'd13
  } st_idx_e;

  localparam int N_ST = 14;

  // Operation codes as presented on the op input.
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  // Control word layout driven to the datapath.
  localparam int C_W         = 12;
  localparam int C_LD_ADDSUB = 0;
  localparam int C_LD_MUL    = 1;
  localparam int C_LD_DIV    = 2;
  localparam int C_INIT      = 3;
  localparam int C_ALU_EN    = 4;
  localparam int C_ALU_SUB   = 5;
  localparam int C_SHL       = 6;
  localparam int C_ASHR      = 7;
  localparam int C_SET_Q     = 8;
  localparam int C_RESTORE   = 9;
  localparam int C_OUT_LO    = 10;
  localparam int C_OUT_HI    = 11;

  // One-hot encoding of a single state index.
  function automatic logic [N_ST-1:0] st_bit(input st_idx_e s);
    logic [N_ST-1:0] v;
    v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_iter.sv
// Iteration counter for the mul/div loops. Counts completed iterations
// from 0 up to LAST and holds there; the sequencer clears it on loop exit.
`timescale 1ns/1ps
module iter_counter #(
  parameter int W    = 3,
  parameter int LAST = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_last
);

  localparam logic [W-1:0] LAST_V = LAST[W-1:0];

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == LAST_V);

  // Counter register: clear wins over increment; increment saturates at LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = w_last;

endmodule

// File: rtl/alu_seq_ctrl.sv
// One-hot sequencer for the multi-cycle ALU: add/sub, radix-2 Booth multiply
// and non-restoring divide. Emits a 12-bit control word per cycle.
// Handshake: ready is high only in IDLE; a start seen while ready is the
// accept, op is latched on that same edge; done pulses for one cycle at the
// end of every accepted operation, and err pulses with it on a divide by zero.
`timescale 1ns/1ps
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             q0,
  input  logic             q_m1,
  input  logic             sign,
  input  logic             dz,
  output logic [C_W-1:0]   c,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [N_ST-1:0]  o_dbg_state,
  output logic [CNT_W-1:0] o_dbg_cnt
);

  logic [N_ST-1:0]  r_state;
  logic [N_ST-1:0]  w_next;
  op_e              r_op;
  logic             w_state_ok;
  logic             w_accept;
  logic [C_W-1:0]   w_c;
  logic             w_done;
  logic             w_err;
  logic             w_ready;
  logic             w_cnt_inc;
  logic             w_cnt_clr;
  logic             w_cnt_last;
  logic [CNT_W-1:0] w_cnt;

  assign w_state_ok = $onehot(r_state);
  assign w_accept   = w_state_ok && r_state[ST_IDLE] && start;

  // Iteration counter shared by the Booth and divide loops.
  iter_counter #(
    .W    (CNT_W),
    .LAST (WIDTH - 1)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_cnt_inc),
    .i_clr  (w_cnt_clr),
    .o_cnt  (w_cnt),
    .o_last (w_cnt_last)
  );

  // One-hot state register; reset lands in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= st_bit(ST_IDLE);
    end else begin
      r_state <= w_next;
    end
  end

  // Operation latch, loaded only on an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op <= OP_ADD;
    end else if (w_accept) begin
      r_op <= op_e'(op);
    end
  end

  // Next-state and control-word decode; a corrupt state vector recovers to IDLE.
  always_comb begin
    w_next    = '0;
    w_c       = '0;
    w_done    = 1'b0;
    w_err     = 1'b0;
    w_ready   = 1'b0;
    w_cnt_inc = 1'b0;
    w_cnt_clr = 1'b0;
    if (!w_state_ok) begin
      w_next = st_bit(ST_IDLE);
    end else begin
      case (1'b1)
        r_state[ST_IDLE]: begin
          w_ready = 1'b1;
          w_next  = start ? st_bit(ST_LOAD) : st_bit(ST_IDLE);
        end
        r_state[ST_LOAD]: begin
          case (r_op)
            OP_MUL:  w_c[C_LD_MUL]    = 1'b1;
            OP_DIV:  w_c[C_LD_DIV]    = 1'b1;
            default: w_c[C_LD_ADDSUB] = 1'b1;
          endcase
          w_next = st_bit(ST_INIT);
        end
        r_state[ST_INIT]: begin
          w_c[C_INIT] = 1'b1;
          case (r_op)
            OP_MUL:  w_next = st_bit(ST_BOOTH);
            OP_DIV:  w_next = dz ? st_bit(ST_ERR) : st_bit(ST_DSHL);
            default: w_next = st_bit(ST_ALU);
          endcase
        end
        r_state[ST_ALU]: begin
          w_c[C_ALU_EN]  = 1'b1;
          w_c[C_ALU_SUB] = r_op[0];
          w_next         = st_bit(ST_OUT_LO);
        end
        r_state[ST_BOOTH]: begin
          // Booth pair 10 subtracts M, 01 adds M, 00/11 skip the ALU.
          w_c[C_ALU_EN]  = q0 ^ q_m1;
          w_c[C_ALU_SUB] = q0 & ~q_m1;
          w_next         = st_bit(ST_SHR);
        end
        r_state[ST_SHR]: begin
          w_c[C_ASHR] = 1'b1;
          if (w_cnt_last) begin
            w_cnt_clr = 1'b1;
            w_next    = st_bit(ST_OUT_LO);
          end else begin
            w_cnt_inc = 1'b1;
            w_next    = st_bit(ST_BOOTH);
          end
        end
        r_state[ST_DSHL]: begin
          w_c[C_SHL] = 1'b1;
          w_next     = st_bit(ST_DALU);
        end
        r_state[ST_DALU]: begin
          // Non-restoring step: subtract M when A was non-negative, else add.
          w_c[C_ALU_EN]  = 1'b1;
          w_c[C_ALU_SUB] = ~sign;
          w_next         = st_bit(ST_DQ);
        end
        r_state[ST_DQ]: begin
          w_c[C_SET_Q] = 1'b1;
          if (w_cnt_last) begin
            w_cnt_clr = 1'b1;
            w_next    = st_bit(ST_DFIX);
          end else begin
            w_cnt_inc = 1'b1;
            w_next    = st_bit(ST_DSHL);
          end
        end
        r_state[ST_DFIX]: begin
          // A negative final remainder is corrected by adding M back.
          w_c[C_RESTORE] = sign;
          w_next         = st_bit(ST_OUT_LO);
        end
        r_state[ST_OUT_LO]: begin
          w_c[C_OUT_LO] = 1'b1;
          w_next        = r_op[1] ? st_bit(ST_OUT_HI) : st_bit(ST_DONE);
        end
        r_state[ST_OUT_HI]: begin
          w_c[C_OUT_HI] = 1'b1;
          w_next        = st_bit(ST_DONE);
        end
        r_state[ST_ERR]: begin
          w_done = 1'b1;
          w_err  = 1'b1;
          w_next = st_bit(ST_IDLE);
        end
        r_state[ST_DONE]: begin
          w_done = 1'b1;
          w_next = st_bit(ST_IDLE);
        end
        default: begin
          w_next = st_bit(ST_IDLE);
        end
      endcase
    end
  end

  assign c           = w_c;
  assign ready       = w_ready;
  assign done        = w_done;
  assign err         = w_err;
  assign o_dbg_state = r_state;
  assign o_dbg_cnt   = w_cnt;

endmodule
